mult_scheduler: RTL and testbench

MULT_SCHEDULER -- requirements
Module: mult_scheduler

---
 rtl/mult_scheduler_if.sv | 22 ++
 rtl/mult_scheduler.sv | 139 +++++++++++++
 tb/tb_mult_scheduler.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_scheduler_if.sv
// Datapath-side bus between the multiply scheduler and the shared 8-bit add-shift datapath.
interface mult_scheduler_if;
  logic [7:0] s;
  logic       clr_ld;
  logic       add;
  logic       sub;
  logic       shift_en;
  logic       reset_c;
  logic       m;
  logic [7:0] aval;
  logic [7:0] bval;

  modport master (
    output s, clr_ld, add, sub, shift_en, reset_c,
    input  m, aval, bval
  );

  modport slave (
    input  s, clr_ld, add, sub, shift_en, reset_c,
    output m, aval, bval
  );
endinterface

// File: rtl/mult_scheduler.sv
// Two-requester round-robin scheduler sequencing a shared 8x8 signed add-shift multiplier.
//   state   | meaning
//   IDLE    | arbitrate requests, pulse grant, latch operands and owner
//   LOAD    | clear A/X, load B with multiplier
//   ADD     | add (or subtract on last iteration) multiplicand when M=1
//   SHIFT   | arithmetic shift X:A:B, advance iteration count
//   CAPTURE | register product {A,B}
//   DONE    | completion pulse to owner
module mult_scheduler (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req0_i,
  input  logic                    req1_i,
  input  logic [7:0]              opa0_i,
  input  logic [7:0]              opb0_i,
  input  logic [7:0]              opa1_i,
  input  logic [7:0]              opb1_i,
  mult_scheduler_if.master        dp,
  output logic                    gnt0_o,
  output logic                    gnt1_o,
  output logic                    done0_o,
  output logic                    done1_o,
  output logic [15:0]             result_o,
  output logic                    busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ADD,
    S_SHIFT,
    S_CAPTURE,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ptr_q, ptr_d;
  logic        owner_q, owner_d;
  logic [7:0]  opa_q, opa_d;
  logic [7:0]  opb_q, opb_d;
  logic [15:0] result_q, result_d;
  logic        grant_sel;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      ptr_q    <= 1'b1;
      owner_q  <= 1'b0;
      opa_q    <= 8'h00;
      opb_q    <= 8'h00;
      result_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
    end
  end

  // On a tie the requester other than the last-granted one wins.
  assign grant_sel = (req0_i && req1_i) ? ~ptr_q : req1_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    result_d    = result_q;
    dp.s        = 8'h00;
    dp.clr_ld   = 1'b0;
    dp.add      = 1'b0;
    dp.sub      = 1'b0;
    dp.shift_en = 1'b0;
    gnt0_o      = 1'b0;
    gnt1_o      = 1'b0;
    done0_o     = 1'b0;
    done1_o     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rst_ni && (req0_i || req1_i)) begin
          gnt0_o  = ~grant_sel;
          gnt1_o  = grant_sel;
          owner_d = grant_sel;
          ptr_d   = grant_sel;
          opa_d   = grant_sel ? opa1_i : opa0_i;
          opb_d   = grant_sel ? opb1_i : opb0_i;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        dp.clr_ld = 1'b1;
        dp.s      = opb_q;
        cnt_d     = 3'd0;
        state_d   = S_ADD;
      end
      S_ADD: begin
        dp.s = opa_q;
        // Multiplier MSB carries negative weight, hence subtract on the last pass.
        if (dp.m) begin
          if (cnt_q == 3'd7) dp.sub = 1'b1;
          else               dp.add = 1'b1;
        end
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        dp.shift_en = 1'b1;
        if (cnt_q == 3'd7) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d   = cnt_q + 3'd1;
          state_d = S_ADD;
        end
      end
      S_CAPTURE: begin
        result_d = {dp.aval, dp.bval};
        state_d  = S_DONE;
      end
      S_DONE: begin
        done0_o = rst_ni && !owner_q;
        done1_o = rst_ni && owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dp.reset_c = ~rst_ni;
  assign result_o   = result_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed bench for mult_scheduler driving a behavioural add-shift datapath.
module tb_mult_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [7:0]  opa0, opb0, opa1, opb1;
  logic        gnt0, gnt1, done0, done1, busy;
  logic [15:0] result;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int gnt0_cnt, done0_cnt, add_cnt, sub_cnt, shift_cnt, sub_cyc;
  int multi_cnt = 0;
  int idle_bad  = 0;

  always #5 clk = ~clk;

  mult_scheduler_if dp();

  mult_scheduler dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req0_i   (req0),
    .req1_i   (req1),
    .opa0_i   (opa0),
    .opb0_i   (opb0),
    .opa1_i   (opa1),
    .opb1_i   (opb1),
    .dp       (dp),
    .gnt0_o   (gnt0),
    .gnt1_o   (gnt1),
    .done0_o  (done0),
    .done1_o  (done1),
    .result_o (result),
    .busy_o   (busy)
  );

  // Shared datapath: X:A:B with sign bit X.
  logic       x_r;
  logic [7:0] a_r, b_r;
  always @(posedge clk) begin
    if (dp.reset_c) begin
      x_r <= 1'b0; a_r <= 8'h00; b_r <= 8'h00;
    end else if (dp.clr_ld) begin
      x_r <= 1'b0; a_r <= 8'h00; b_r <= dp.s;
    end else if (dp.add) begin
      {x_r, a_r} <= {a_r[7], a_r} + {dp.s[7], dp.s};
    end else if (dp.sub) begin
      {x_r, a_r} <= {a_r[7], a_r} - {dp.s[7], dp.s};
    end else if (dp.shift_en) begin
      a_r <= {x_r, a_r[7:1]};
      b_r <= {a_r[0], b_r[7:1]};
    end
  end
  assign dp.m    = b_r[0];
  assign dp.aval = a_r;
  assign dp.bval = b_r;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (gnt0)        gnt0_cnt++;
    if (done0)       done0_cnt++;
    if (dp.add)      add_cnt++;
    if (dp.sub)      begin sub_cnt++; sub_cyc = cyc; end
    if (dp.shift_en) shift_cnt++;
    if ((int'(dp.clr_ld) + int'(dp.add) + int'(dp.sub) + int'(dp.shift_en)) > 1) multi_cnt++;
    if (!busy && (dp.clr_ld || dp.add || dp.sub || dp.shift_en || dp.s != 8'h00)) idle_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    gnt0_cnt = 0; done0_cnt = 0; add_cnt = 0; sub_cnt = 0; shift_cnt = 0; sub_cyc = -1;
  endtask

  task automatic wait_done(output int dcyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done0 || done1) begin ok = 1'b1; break; end
    end
    dcyc = cyc;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  // Starts in an IDLE cycle at posedge+1; operands are scrambled after the grant.
  task automatic do_single(input bit who, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp_res, input int n_add, input int n_sub,
                           input string tag);
    int start, d;
    bit ok;
    clear_counts();
    if (who) begin req1 = 1'b1; opa1 = a; opb1 = b; end
    else     begin req0 = 1'b1; opa0 = a; opb0 = b; end
    @(negedge clk);
    chk({tag, "_gnt0"}, 32'(gnt0), 32'(who == 1'b0));
    chk({tag, "_gnt1"}, 32'(gnt1), 32'(who == 1'b1));
    start = cyc;
    step();
    req0 = 1'b0; req1 = 1'b0;
    if (who) begin opa1 = ~a; opb1 = ~b; end
    else     begin opa0 = ~a; opb0 = ~b; end
    wait_done(d, ok);
    chk({tag, "_done_seen"}, 32'(ok), 32'd1);
    chk({tag, "_latency"}, 32'(d - start), 32'd19);
    chk({tag, "_done0"}, 32'(done0), 32'(who == 1'b0));
    chk({tag, "_done1"}, 32'(done1), 32'(who == 1'b1));
    chk({tag, "_result"}, 32'(result), 32'(exp_res));
    chk({tag, "_adds"}, 32'(add_cnt), 32'(n_add));
    chk({tag, "_subs"}, 32'(sub_cnt), 32'(n_sub));
    chk({tag, "_shifts"}, 32'(shift_cnt), 32'd8);
    if (n_sub > 0) chk({tag, "_sub_cycle"}, 32'(sub_cyc - start), 32'd16);
    step();
    @(negedge clk);
    chk({tag, "_idle_after"}, 32'(busy), 32'd0);
    step();
  endtask

  initial begin
    int start, prev, d;
    bit ok;
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    opa0 = 8'h00; opb0 = 8'h00; opa1 = 8'h00; opb1 = 8'h00;
    clear_counts();
    step(); step();

    // Reset behaviour, including no grant while reset is held.
    req0 = 1'b1;
    @(negedge clk);
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_reset_c", 32'(dp.reset_c), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'h0000);
    chk("rst_s", 32'(dp.s), 32'h00);
    chk("rst_strobes", 32'({dp.clr_ld, dp.add, dp.sub, dp.shift_en}), 32'd0);
    step();
    req0 = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("rst_reset_c_rel", 32'(dp.reset_c), 32'd0);
    step();

    do_single(1'b0, 8'h07, 8'h03, 16'h0015, 2, 0, "r0_7x3");
    do_single(1'b1, 8'hFE, 8'h05, 16'hFFF6, 2, 0, "r1_m2x5");
    do_single(1'b0, 8'h03, 8'hFF, 16'hFFFD, 7, 1, "r0_3xm1");
    do_single(1'b1, 8'h80, 8'h80, 16'h4000, 0, 1, "r1_m128sq");

    // Simultaneous requests held high: grants alternate starting with 0.
    reset_dut();
    opa0 = 8'h02; opb0 = 8'h03; opa1 = 8'h04; opb1 = 8'h05;
    req0 = 1'b1; req1 = 1'b1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("tie_gnt0", 32'(gnt0), 32'(k % 2 == 0));
      chk("tie_gnt1", 32'(gnt1), 32'(k % 2 == 1));
      if (k > 0) chk("tie_gap", 32'(cyc - prev), 32'd20);
      prev = cyc;
      wait_done(d, ok);
      chk("tie_done_seen", 32'(ok), 32'd1);
      chk("tie_done1", 32'(done1), 32'(k % 2 == 1));
      chk("tie_result", 32'(result), (k % 2 == 1) ? 32'h0014 : 32'h0006);
      step();
      if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
    end
    @(negedge clk);
    chk("tie_end_busy", 32'(busy), 32'd0);
    chk("tie_end_gnt0", 32'(gnt0), 32'd0);
    step();

    // Reset in cycle 8 aborts the operation.
    reset_dut();
    clear_counts();
    req0 = 1'b1; opa0 = 8'h07; opb0 = 8'h03;
    @(negedge clk);
    chk("abort_gnt0", 32'(gnt0), 32'd1);
    start = cyc;
    step();
    req0 = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_cycle", 32'(cyc - start), 32'd8);
    chk("abort_busy_pre", 32'(busy), 32'd1);
    chk("abort_reset_c", 32'(dp.reset_c), 32'd1);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_strobes", 32'({dp.clr_ld, dp.add, dp.sub, dp.shift_en}), 32'd0);
    chk("abort_s", 32'(dp.s), 32'h00);
    repeat (25) step();
    chk("abort_no_done0", 32'(done0_cnt), 32'd0);
    chk("abort_result", 32'(result), 32'h0000);

    // A request pulsed while busy and dropped before IDLE is never granted.
    clear_counts();
    req1 = 1'b1; opa1 = 8'h01; opb1 = 8'h01;
    @(negedge clk);
    chk("drop_gnt1", 32'(gnt1), 32'd1);
    step();
    req1 = 1'b0;
    repeat (4) step();
    req0 = 1'b1;
    step();
    req0 = 1'b0;
    wait_done(d, ok);
    chk("drop_done_seen", 32'(ok), 32'd1);
    chk("drop_done1", 32'(done1), 32'd1);
    repeat (25) step();
    chk("drop_no_gnt0", 32'(gnt0_cnt), 32'd0);
    chk("drop_no_done0", 32'(done0_cnt), 32'd0);
    chk("drop_result", 32'(result), 32'h0001);

    chk("strobe_onehot", 32'(multi_cnt), 32'd0);
    chk("idle_quiet", 32'(idle_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
